// File: rtl/ti_quad_eval_pipe.sv
// ti_quad_eval_pipe: two-stage pipelined evaluator of N_OUT quadratic boolean functions over one N_IN-bit share
module ti_quad_eval_pipe #(
  parameter int N_IN = 16,
  parameter int N_OUT = 1,
  localparam int TERMS = 1 + N_IN + N_IN*(N_IN-1)/2,
  localparam int NT = N_OUT*TERMS,
  localparam int AW = $clog2(NT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic             cfg_data,
  output logic             cfg_ready,
  output logic             cfg_err
);
  logic [NT-1:0] r_coef;
  logic [N_OUT*N_IN-1:0] r_s1, w_s1;
  logic [N_OUT-1:0] r_out, w_s2;
  logic r_v1, r_v2, r_err;
  logic w_adv, w_acc, w_empty, w_wr_ok;
  assign w_adv = !r_v2 | out_ready;
  assign in_ready = rst_n & w_adv & !cfg_we;
  assign w_acc = in_valid & in_ready;
  assign w_empty = !r_v1 & !r_v2;
  assign cfg_ready = rst_n & w_empty & !in_valid;
  // a same-cycle input is refused whenever cfg_we is high, so only in-flight vectors block a write
  assign w_wr_ok = w_empty & ({1'b0, cfg_addr} < (AW+1)'(NT));
  assign out_data = r_out;
  assign out_valid = r_v2;
  assign cfg_err = r_err;
  // each stage-1 bit only gathers terms owned by row i, so rows first meet behind the register
  always_comb begin
    w_s1 = '0;
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) begin
        w_s1[j*N_IN+i] = r_coef[j*TERMS+1+i] & in_data[i];
        for (int k = i + 1; k < N_IN; k++)
          w_s1[j*N_IN+i] ^= in_data[i] & in_data[k] & r_coef[j*TERMS+N_IN+1+i*(2*N_IN-i-1)/2+k-i-1];
      end
  end
  always_comb begin
    w_s2 = '0;
    for (int j = 0; j < N_OUT; j++)
      w_s2[j] = r_coef[j*TERMS] ^ (^r_s1[j*N_IN +: N_IN]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef <= '0;
      r_s1 <= '0;
      r_out <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_adv) begin
        r_v1 <= w_acc;
        r_v2 <= r_v1;
        r_s1 <= w_s1;
        r_out <= w_s2;
      end
      if (cfg_we && w_wr_ok) r_coef[cfg_addr] <= cfg_data;
      else if (cfg_we) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ti_quad_eval_pipe.sv
// tb_ti_quad_eval_pipe: directed scenarios plus random traffic checked against a term-by-term quadratic model
module tb_ti_quad_eval_pipe;
  localparam int N_IN = 16;
  localparam int N_OUT = 2;
  localparam int T = 1 + N_IN + N_IN*(N_IN-1)/2;
  localparam int NT = N_OUT*T;
  localparam int AW = $clog2(NT);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N_IN-1:0] in_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [N_OUT-1:0] out_data;
  logic out_valid, out_ready = 1'b1;
  logic cfg_we = 1'b0, cfg_data = 1'b0, cfg_ready, cfg_err;
  logic [AW-1:0] cfg_addr = '0;

  ti_quad_eval_pipe #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct {logic [N_OUT-1:0] v; int acc;} ent_t;
  ent_t q[$];
  bit m_coef [NT];
  bit m_err = 1'b0;
  bit e_ov, was_empty;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N_OUT-1:0] eval(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] r;
    int p;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      r[j] = m_coef[j*T];
      for (int i = 0; i < N_IN; i++) r[j] ^= m_coef[j*T+1+i] & x[i];
      p = 0;
      for (int i = 0; i < N_IN; i++)
        for (int k = i + 1; k < N_IN; k++) begin
          r[j] ^= m_coef[j*T+1+N_IN+p] & x[i] & x[k];
          p++;
        end
    end
    return r;
  endfunction

  task automatic clear_model();
    q.delete();
    foreach (m_coef[a]) m_coef[a] = 1'b0;
    m_err = 1'b0;
  endtask

  // compare, then advance the model by the handshakes the coming edge will take
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      clear_model();
    end else begin
      e_ov = q.size() > 0 && cyc - q[0].acc >= 2;
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      if (out_valid && e_ov) chk("out_data", 32'(out_data), 32'(q[0].v));
      chk("in_ready", 32'(in_ready), 32'(!cfg_we && !(e_ov && !out_ready)));
      chk("cfg_ready", 32'(cfg_ready), 32'(q.size() == 0 && !in_valid));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      was_empty = q.size() == 0;
      if (e_ov && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{eval(in_data), cyc});
      if (cfg_we) begin
        if (was_empty && int'(cfg_addr) < NT) m_coef[cfg_addr] = cfg_data;
        else m_err = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_cfg_ready", 32'(cfg_ready), 1);
    step();
  endtask

  task automatic wr(input int a, input logic d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic xfer(input logic [N_IN-1:0] x, output logic [N_OUT-1:0] d, output int lat);
    in_data = x;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    d = '0;
    @(negedge clk);
    chk("xfer_accept", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = t;
        d = out_data;
        break;
      end
      step();
    end
    step();
  endtask

  logic [N_OUT-1:0] d;
  int lat, got, guard;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #2 rst_n = 1'b0;
    do_reset();
    // no coefficients written: every function is zero
    xfer(16'hFFFF, d, lat);
    chk("s031_data", 32'(d), 0);
    chk("s031_latency", 32'(lat), 2);
    // L[2] and Q[2][3] of output 0
    wr(3, 1'b1);
    wr(46, 1'b1);
    xfer(16'h0004, d, lat);
    chk("s032_x0004", 32'(d), 32'h1);
    chk("s032_latency", 32'(lat), 2);
    xfer(16'h000C, d, lat);
    chk("s032_x000C", 32'(d), 32'h0);
    // write and input collide on an empty pipeline: write wins
    cfg_we = 1'b1;
    cfg_addr = AW'(46);
    cfg_data = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h000C;
    #1;
    chk("s035_in_ready", 32'(in_ready), 0);
    step();
    cfg_we = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    xfer(16'h000C, d, lat);
    chk("s035_applied", 32'(d), 32'h1);
    chk("s035_no_err", 32'(cfg_err), 0);
    // write while a vector is in flight is dropped
    in_data = 16'h0004;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wr(3, 1'b0);
    chk("s034_err", 32'(cfg_err), 1);
    repeat (4) step();
    xfer(16'h0004, d, lat);
    chk("s034_unchanged", 32'(d), 32'h1);
    repeat (20) step();
    chk("s034_sticky", 32'(cfg_err), 1);
    do_reset();
    chk("s034_cleared", 32'(cfg_err), 0);
    // address past the last coefficient
    wr(NT, 1'b1);
    chk("oob_err", 32'(cfg_err), 1);
    xfer(16'hFFFF, d, lat);
    chk("oob_no_effect", 32'(d), 0);
    do_reset();
    for (int a = 0; a < NT; a++) wr(a, 1'($urandom));
    // 8 back-to-back vectors under a 1,0,0,1 out_ready pattern
    got = 0;
    guard = 0;
    while (got < 8 && guard < 200) begin
      out_ready = pat[guard % 4];
      in_valid = 1'b1;
      in_data = N_IN'($urandom);
      @(negedge clk);
      if (in_ready) got++;
      step();
      guard++;
    end
    chk("s033_sent", 32'(got), 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("s033_drained", 32'(q.size()), 0);
    // random traffic with occasional writes, many of them dropped
    for (int c = 0; c < 3000; c++) begin
      in_valid = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      in_data = N_IN'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      cfg_we = $urandom_range(0, 15) == 0;
      cfg_addr = AW'($urandom);
      cfg_data = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("rand_drained", 32'(q.size()), 0);
    // reset pulse between edges with two vectors in flight
    do_reset();
    in_valid = 1'b1;
    in_data = N_IN'($urandom);
    step();
    in_data = N_IN'($urandom);
    step();
    in_valid = 1'b0;
    chk("s036_pre_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("s036_out_valid", 32'(out_valid), 0);
    chk("s036_in_ready", 32'(in_ready), 0);
    chk("s036_cfg_ready", 32'(cfg_ready), 0);
    clear_model();
    #1 rst_n = 1'b1;
    repeat (6) step();
    chk("s036_nothing", 32'(out_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
